// File: rtl/alu_md_if.sv
// ---------------------------------------------------------------------------
// alu_md_if -- request/response bundle for alu_md_unit.
//
// Signals (directions as seen by the unit, i.e. the slave modport):
//   valid_in      in   operation request
//   alu_op[1:0]   in   00 add, 01 sub, 1x decode funct
//   funct[5:0]    in   R-type function field
//   a, b          in   operands (a = rs, b = rt)
//   ready_out     out  high when a request can be accepted
//   result        out  registered result
//   result_valid  out  one-cycle pulse qualifying result and flags
//   ovf           out  signed overflow flag (add/sub with trap funct)
//   div_zero      out  divide-by-zero flag
//   hi, lo        out  architectural HI/LO registers
// ---------------------------------------------------------------------------
interface alu_md_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready_out;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             ovf;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output valid_in, alu_op, funct, a, b,
    input  ready_out, result, result_valid, ovf, div_zero, hi, lo
  );

  modport slave (
    input  valid_in, alu_op, funct, a, b,
    output ready_out, result, result_valid, ovf, div_zero, hi, lo
  );
endinterface

// File: rtl/alu_md_unit.sv
// ---------------------------------------------------------------------------
// alu_md_unit -- MIPS-style integer ALU with iterative multiply/divide and
// architectural HI/LO registers.
//
// Ports:
//   clk   in   single clock, rising edge
//   rst   in   asynchronous active-high reset
//   bus   slave modport of alu_md_if (request, result, flags, hi/lo)
//
// Single-cycle ops register their result on the acceptance edge and pulse
// result_valid in the following cycle; ready_out stays high for them.
// mult/multu/div/divu run WIDTH one-bit iterations on operand magnitudes
// (shift-add multiply, restoring divide), then a DONE cycle applies sign
// correction and commits hi/lo/result, so the pulse appears WIDTH+1 cycles
// after acceptance.
// ---------------------------------------------------------------------------
module alu_md_unit #(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst,
  alu_md_if.slave bus
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc_hi/acc_lo: partial product (mul) or remainder/quotient (div).
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  // Multiplicand magnitude (mul) or divisor magnitude (div).
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dzero_q, dzero_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             ovf_q, ovf_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Single-cycle decode
  logic [WIDTH-1:0] sum, diff, sc_result;
  logic             sc_ovf, wr_hi, wr_lo, start_mul, start_div, sgn;
  logic             accept;

  // Iteration / finalisation datapath
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept = bus.valid_in && (state_q == IDLE);

  always_comb begin
    sum       = bus.a + bus.b;
    diff      = bus.a - bus.b;
    sc_result = '0;
    sc_ovf    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    sgn       = 1'b0;
    if (!bus.alu_op[1]) begin
      sc_result = bus.alu_op[0] ? diff : sum;
    end else begin
      case (bus.funct)
        F_ADD: begin
          sc_result = sum;
          sc_ovf    = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
        end
        F_ADDU: sc_result = sum;
        F_SUB: begin
          sc_result = diff;
          sc_ovf    = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
        end
        F_SUBU:  sc_result = diff;
        F_AND:   sc_result = bus.a & bus.b;
        F_OR:    sc_result = bus.a | bus.b;
        F_XOR:   sc_result = bus.a ^ bus.b;
        F_NOR:   sc_result = ~(bus.a | bus.b);
        F_SLT:   sc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
        F_SLTU:  sc_result = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
        F_MFHI:  sc_result = hi_q;
        F_MFLO:  sc_result = lo_q;
        F_MTHI:  wr_hi = 1'b1;
        F_MTLO:  wr_lo = 1'b1;
        F_MULT:  begin start_mul = 1'b1; sgn = 1'b1; end
        F_MULTU: start_mul = 1'b1;
        F_DIV:   begin start_div = 1'b1; sgn = 1'b1; end
        F_DIVU:  start_div = 1'b1;
        default: sc_result = '0;
      endcase
    end
  end

  always_comb begin
    // Magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    a_mag     = (sgn && bus.a[MSB]) ? -bus.a : bus.a;
    b_mag     = (sgn && bus.b[MSB]) ? -bus.b : bus.b;
    mul_sum   = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, opnd_q}) : {1'b0, acc_hi_q};
    div_shift = {acc_hi_q, acc_lo_q[MSB]};
    div_trial = div_shift - {1'b0, opnd_q};
    prod_fix  = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    quo_fix   = neg_res_q ? -acc_lo_q : acc_lo_q;
    rem_fix   = neg_rem_q ? -acc_hi_q : acc_hi_q;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_hi_d       = acc_hi_q;
    acc_lo_d       = acc_lo_q;
    opnd_d         = opnd_q;
    op_a_d         = op_a_q;
    neg_res_d      = neg_res_q;
    neg_rem_d      = neg_rem_q;
    dzero_d        = dzero_q;
    is_div_d       = is_div_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    ovf_d          = 1'b0;
    div_zero_d     = 1'b0;
    hi_d           = hi_q;
    lo_d           = lo_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (start_mul || start_div) begin
            state_d   = start_mul ? MUL : DIV;
            cnt_d     = '0;
            acc_hi_d  = '0;
            acc_lo_d  = start_mul ? b_mag : a_mag;
            opnd_d    = start_mul ? a_mag : b_mag;
            op_a_d    = bus.a;
            neg_res_d = sgn && (bus.a[MSB] ^ bus.b[MSB]);
            neg_rem_d = sgn && bus.a[MSB];
            dzero_d   = start_div && (bus.b == '0);
            is_div_d  = start_div;
          end else begin
            result_d       = sc_result;
            result_valid_d = 1'b1;
            ovf_d          = sc_ovf;
            if (wr_hi) hi_d = bus.a;
            if (wr_lo) lo_d = bus.a;
          end
        end
      end

      MUL: begin
        // Shift-add: add multiplicand when LSB of multiplier is set, then
        // shift the whole {acc_hi, acc_lo} right by one.
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[MSB:1]};
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end

      DIV: begin
        // Restoring step: the remainder stays below the divisor, so both
        // the trial difference and the shifted value fit in WIDTH bits.
        if (div_shift >= {1'b0, opnd_q}) begin
          acc_hi_d = div_trial[MSB:0];
          acc_lo_d = {acc_lo_q[MSB-1:0], 1'b1};
        end else begin
          acc_hi_d = div_shift[MSB:0];
          acc_lo_d = {acc_lo_q[MSB-1:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end

      DONE: begin
        state_d        = IDLE;
        cnt_d          = '0;
        result_valid_d = 1'b1;
        if (is_div_q) begin
          if (dzero_q) begin
            hi_d       = op_a_q;
            lo_d       = '1;
            div_zero_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[MSB:0];
        end
        result_d = lo_d;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      acc_hi_q       <= '0;
      acc_lo_q       <= '0;
      opnd_q         <= '0;
      op_a_q         <= '0;
      neg_res_q      <= 1'b0;
      neg_rem_q      <= 1'b0;
      dzero_q        <= 1'b0;
      is_div_q       <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      ovf_q          <= 1'b0;
      div_zero_q     <= 1'b0;
      hi_q           <= '0;
      lo_q           <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      acc_hi_q       <= acc_hi_d;
      acc_lo_q       <= acc_lo_d;
      opnd_q         <= opnd_d;
      op_a_q         <= op_a_d;
      neg_res_q      <= neg_res_d;
      neg_rem_q      <= neg_rem_d;
      dzero_q        <= dzero_d;
      is_div_q       <= is_div_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      ovf_q          <= ovf_d;
      div_zero_q     <= div_zero_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
    end
  end

  assign bus.ready_out    = (state_q == IDLE);
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.ovf          = ovf_q;
  assign bus.div_zero     = div_zero_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;

endmodule

// File: tb/tb_alu_md_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_md_unit -- directed self-checking bench for alu_md_unit.
// Two instances: WIDTH=32 (main checks) and WIDTH=8 (short-width checks).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_alu_md_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_md_if #(.WIDTH(32)) if32();
  alu_md_if #(.WIDTH(8))  if8();

  alu_md_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
  alu_md_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        ov;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
    if32.valid_in = 1'b1;
    if32.alu_op   = op;
    if32.funct    = f;
    if32.a        = a;
    if32.b        = b;
  endtask

  task automatic test_reset();
    if32.valid_in = 1'b0; if32.alu_op = 2'b00; if32.funct = 6'd0;
    if32.a = '0; if32.b = '0;
    if8.valid_in = 1'b0; if8.alu_op = 2'b00; if8.funct = 6'd0;
    if8.a = '0; if8.b = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({if32.ready_out, if32.result_valid, if32.ovf, if32.div_zero} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 1000",
               {if32.ready_out, if32.result_valid, if32.ovf, if32.div_zero});
    end
    n_tests++;
    if ({if32.result, if32.hi, if32.lo} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_regs got %h/%h/%h exp 0/0/0", if32.result, if32.hi, if32.lo);
    end
    n_tests++;
    if ({if8.ready_out, if8.result_valid, if8.hi, if8.lo} !== 18'b10_0000_0000_0000_0000) begin
      n_fail++;
      $display("FAIL reset_w8 got rdy=%b rv=%b hi=%h lo=%h exp 1/0/00/00",
               if8.ready_out, if8.result_valid, if8.hi, if8.lo);
    end
    step();
    step();
    rst = 1'b0;
    $display("[TB] reset released");
  endtask

  task automatic test_add_ovf();
    drive32(2'b10, 6'b100000, 32'h7FFF_FFFF, 32'h1);
    step();
    drive32(2'b10, 6'b100001, 32'h7FFF_FFFF, 32'h1);
    n_tests++;
    if ({if32.result_valid, if32.ovf, if32.result} !== {2'b11, 32'h8000_0000}) begin
      n_fail++;
      $display("FAIL add_ovf got rv=%b ovf=%b res=%h exp 1/1/80000000",
               if32.result_valid, if32.ovf, if32.result);
    end
    $display("[TB] add 7fffffff+1 -> %h ovf=%b", if32.result, if32.ovf);
    step();
    if32.valid_in = 1'b0;
    n_tests++;
    if ({if32.result_valid, if32.ovf, if32.result} !== {2'b10, 32'h8000_0000}) begin
      n_fail++;
      $display("FAIL addu_noovf got rv=%b ovf=%b res=%h exp 1/0/80000000",
               if32.result_valid, if32.ovf, if32.result);
    end
    $display("[TB] addu 7fffffff+1 -> %h ovf=%b", if32.result, if32.ovf);
    step();
    n_tests++;
    if ({if32.result_valid, if32.ovf, if32.div_zero} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_flags got %b exp 000",
               {if32.result_valid, if32.ovf, if32.div_zero});
    end
  endtask

  task automatic test_back_to_back();
    vec_t vecs[12];
    vecs[0]  = '{2'b00, 6'b000000, 32'd5,         32'd3,         32'd8,         1'b0};
    vecs[1]  = '{2'b01, 6'b000000, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{2'b10, 6'b100010, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1};
    vecs[3]  = '{2'b11, 6'b100011, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0};
    vecs[4]  = '{2'b10, 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
    vecs[5]  = '{2'b10, 6'b100101, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0};
    vecs[6]  = '{2'b10, 6'b100110, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0};
    vecs[7]  = '{2'b10, 6'b100111, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, 1'b0};
    vecs[8]  = '{2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0};
    vecs[9]  = '{2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
    vecs[10] = '{2'b00, 6'b100000, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0};
    vecs[11] = '{2'b10, 6'b111111, 32'h1234_5678, 32'd9,         32'd0,         1'b0};
    for (int i = 0; i < 12; i++) begin
      drive32(vecs[i].op, vecs[i].f, vecs[i].a, vecs[i].b);
      step();
      n_tests++;
      if ({if32.ready_out, if32.result_valid, if32.ovf, if32.result} !==
          {2'b11, vecs[i].ov, vecs[i].r}) begin
        n_fail++;
        $display("FAIL b2b_%0d got rdy=%b rv=%b ovf=%b res=%h exp 1/1/%b/%h", i,
                 if32.ready_out, if32.result_valid, if32.ovf, if32.result,
                 vecs[i].ov, vecs[i].r);
      end
      $display("[TB] op=%b f=%b a=%h b=%h -> %h ovf=%b", vecs[i].op, vecs[i].f,
               vecs[i].a, vecs[i].b, if32.result, if32.ovf);
    end
    if32.valid_in = 1'b0;
    step();
  endtask

  task automatic test_hilo();
    drive32(2'b10, 6'b010001, 32'h1234_5678, 32'hDEAD_BEEF);
    step();
    n_tests++;
    if ({if32.result_valid, if32.result, if32.hi} !== {1'b1, 32'd0, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL mthi got rv=%b res=%h hi=%h exp 1/0/12345678",
               if32.result_valid, if32.result, if32.hi);
    end
    drive32(2'b10, 6'b010011, 32'h9ABC_DEF0, 32'd0);
    step();
    n_tests++;
    if ({if32.result_valid, if32.result, if32.lo, if32.hi} !==
        {1'b1, 32'd0, 32'h9ABC_DEF0, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL mtlo got rv=%b res=%h lo=%h hi=%h exp 1/0/9abcdef0/12345678",
               if32.result_valid, if32.result, if32.lo, if32.hi);
    end
    drive32(2'b10, 6'b010000, 32'd0, 32'd0);
    step();
    n_tests++;
    if (if32.result !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL mfhi got %h exp 12345678", if32.result);
    end
    drive32(2'b10, 6'b010010, 32'd0, 32'd0);
    step();
    n_tests++;
    if (if32.result !== 32'h9ABC_DEF0) begin
      n_fail++;
      $display("FAIL mflo got %h exp 9abcdef0", if32.result);
    end
    drive32(2'b10, 6'b000000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    if32.valid_in = 1'b0;
    n_tests++;
    if ({if32.result_valid, if32.result, if32.hi, if32.lo} !==
        {1'b1, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0}) begin
      n_fail++;
      $display("FAIL unknown_funct got rv=%b res=%h hi=%h lo=%h exp 1/0/12345678/9abcdef0",
               if32.result_valid, if32.result, if32.hi, if32.lo);
    end
    $display("[TB] hi/lo moves hi=%h lo=%h", if32.hi, if32.lo);
  endtask

  // One mult/div on the 32-bit unit: scrambles the inputs while busy.
  task automatic run_md32(input string name, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz);
    int bad_busy;
    bad_busy = 0;
    drive32(2'b10, f, a, b);
    step();
    if32.valid_in = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      if ({if32.ready_out, if32.result_valid, if32.div_zero} !== 3'b000) bad_busy++;
      if32.a     = $urandom;
      if32.b     = $urandom;
      if32.funct = 6'(k);
      step();
    end
    n_tests++;
    if (bad_busy != 0) begin
      n_fail++;
      $display("FAIL %s_busy got %0d bad busy cycles exp 0", name, bad_busy);
    end
    n_tests++;
    if ({if32.ready_out, if32.result_valid, if32.div_zero, if32.ovf,
         if32.hi, if32.lo, if32.result} !==
        {2'b11, exp_dz, 1'b0, exp_hi, exp_lo, exp_lo}) begin
      n_fail++;
      $display("FAIL %s_done got rdy=%b rv=%b dz=%b ovf=%b hi=%h lo=%h res=%h exp 1/1/%b/0/%h/%h/%h",
               name, if32.ready_out, if32.result_valid, if32.div_zero, if32.ovf,
               if32.hi, if32.lo, if32.result, exp_dz, exp_hi, exp_lo, exp_lo);
    end
    $display("[TB] %s a=%h b=%h -> hi=%h lo=%h dz=%b", name, a, b, if32.hi, if32.lo,
             if32.div_zero);
    step();
    n_tests++;
    if ({if32.result_valid, if32.div_zero, if32.hi, if32.lo} !==
        {2'b00, exp_hi, exp_lo}) begin
      n_fail++;
      $display("FAIL %s_after got rv=%b dz=%b hi=%h lo=%h exp 0/0/%h/%h",
               name, if32.result_valid, if32.div_zero, if32.hi, if32.lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_muldiv();
    run_md32("multu_max", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_md32("mult_neg", 6'b011000, 32'hFFFF_FFFD, 32'd5,
             32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_md32("div_m7_2", 6'b011010, 32'hFFFF_FFF9, 32'd2,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    drive32(2'b10, 6'b010010, 32'd0, 32'd0);
    step();
    if32.valid_in = 1'b0;
    n_tests++;
    if ({if32.result_valid, if32.result} !== {1'b1, 32'hFFFF_FFFD}) begin
      n_fail++;
      $display("FAIL mflo_after_div got rv=%b res=%h exp 1/fffffffd",
               if32.result_valid, if32.result);
    end
    run_md32("div_7_m2", 6'b011010, 32'd7, 32'hFFFF_FFFE,
             32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_md32("divu_by0", 6'b011011, 32'd5, 32'd0,
             32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
    run_md32("div_minneg", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h0000_0000, 32'h8000_0000, 1'b0);
    run_md32("divu_100_7", 6'b011011, 32'd100, 32'd7,
             32'h0000_0002, 32'h0000_000E, 1'b0);
  endtask

  task automatic test_abort();
    int bad;
    bad = 0;
    drive32(2'b10, 6'b011000, 32'd3, 32'd5);
    step();
    if32.valid_in = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({if32.ready_out, if32.hi, if32.lo} !== {1'b1, 64'd0}) begin
      n_fail++;
      $display("FAIL abort_async got rdy=%b hi=%h lo=%h exp 1/0/0",
               if32.ready_out, if32.hi, if32.lo);
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if ({if32.result_valid, if32.hi, if32.lo} !== 65'd0 || if32.ready_out !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_quiet got %0d bad cycles exp 0", bad);
    end
    $display("[TB] mult aborted by reset hi=%h lo=%h", if32.hi, if32.lo);
  endtask

  task automatic test_w8();
    int bad_busy;
    bad_busy = 0;
    if8.valid_in = 1'b1; if8.alu_op = 2'b10; if8.funct = 6'b100000;
    if8.a = 8'h7F; if8.b = 8'h01;
    step();
    n_tests++;
    if ({if8.result_valid, if8.ovf, if8.result} !== {2'b11, 8'h80}) begin
      n_fail++;
      $display("FAIL w8_add_ovf got rv=%b ovf=%b res=%h exp 1/1/80",
               if8.result_valid, if8.ovf, if8.result);
    end
    if8.funct = 6'b011000; if8.a = 8'h80; if8.b = 8'hFF;
    step();
    // Hold a different request while busy; it must be ignored.
    if8.funct = 6'b010001; if8.a = 8'h55;
    for (int k = 0; k <= 8; k++) begin
      if ({if8.ready_out, if8.result_valid} !== 2'b00) bad_busy++;
      if (k < 8) step();
    end
    n_tests++;
    if (bad_busy != 0) begin
      n_fail++;
      $display("FAIL w8_busy got %0d bad busy cycles exp 0", bad_busy);
    end
    step();
    if8.valid_in = 1'b0;
    n_tests++;
    if ({if8.ready_out, if8.result_valid, if8.hi, if8.lo, if8.result} !==
        {2'b11, 8'h00, 8'h80, 8'h80}) begin
      n_fail++;
      $display("FAIL w8_mult got rdy=%b rv=%b hi=%h lo=%h res=%h exp 1/1/00/80/80",
               if8.ready_out, if8.result_valid, if8.hi, if8.lo, if8.result);
    end
    $display("[TB] w8 mult 80*ff -> hi=%h lo=%h", if8.hi, if8.lo);
    step();
    n_tests++;
    if ({if8.result_valid, if8.hi, if8.lo} !== {1'b0, 8'h00, 8'h80}) begin
      n_fail++;
      $display("FAIL w8_held_ignored got rv=%b hi=%h lo=%h exp 0/00/80",
               if8.result_valid, if8.hi, if8.lo);
    end
    // 8-bit divu 200/7 = 28 rem 4
    if8.valid_in = 1'b1; if8.funct = 6'b011011; if8.a = 8'd200; if8.b = 8'd7;
    step();
    if8.valid_in = 1'b0;
    repeat (9) step();
    n_tests++;
    if ({if8.result_valid, if8.hi, if8.lo} !== {1'b1, 8'd4, 8'd28}) begin
      n_fail++;
      $display("FAIL w8_divu got rv=%b hi=%h lo=%h exp 1/04/1c",
               if8.result_valid, if8.hi, if8.lo);
    end
    $display("[TB] w8 divu 200/7 -> hi=%h lo=%h", if8.hi, if8.lo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_ovf();
    test_back_to_back();
    test_hilo();
    test_muldiv();
    test_abort();
    test_w8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_md_unit.md
ALU_MD_UNIT -- requirements
Module: alu_md_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits; legal values are even and >= 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port valid_in  input  1  operation request.
REQ-005 SHALL have port alu_op  input  2  00 add, 01 sub, 1x decode funct.
REQ-006 SHALL have port funct  input  6  R-type function field.
REQ-007 SHALL have ports a, b  input  WIDTH  operands (a = rs, b = rt).
REQ-008 SHALL have port ready_out  output  1  high when a request can be accepted.
REQ-009 SHALL have port result  output  WIDTH  registered result.
REQ-010 SHALL have port result_valid  output  1  one-cycle pulse qualifying result and flags.
REQ-011 SHALL have port ovf  output  1  signed overflow flag for add/sub.
REQ-012 SHALL have port div_zero  output  1  divide-by-zero flag.
REQ-013 SHALL have ports hi, lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-014 A request SHALL be accepted on a rising edge where valid_in=1 and ready_out=1; with valid_in=1 and ready_out=0 the request SHALL be ignored.
REQ-015 Decode rules:
- alu_op=00: add.
- alu_op=01: sub.
- alu_op=1x, by funct: 100000 add (ovf); 100001 addu; 100010 sub (ovf); 100011 subu; 100100 and; 100101 or; 100110 xor; 100111 nor; 101010 slt signed; 101011 sltu; 010000 mfhi; 010010 mflo; 010001 mthi; 010011 mtlo; 011000 mult; 011001 multu; 011010 div; 011011 divu.
- Any other funct: result 0, no HI/LO change.
REQ-016 Single-cycle ops (everything except mult/multu/div/divu) SHALL register result and pulse result_valid exactly one cycle after acceptance; ready_out SHALL stay 1, giving back-to-back throughput.
REQ-017 Arithmetic SHALL be modulo 2^WIDTH; slt/sltu SHALL return 1 or 0 zero-extended.
REQ-018 ovf SHALL be 1 only for funct 100000/100010 when the signed result overflows, and 0 otherwise; the result is still written.
REQ-019 mthi/mtlo SHALL write a into hi/lo at the acceptance edge, with result=0 and result_valid pulsed.
REQ-020 mfhi/mflo SHALL return the hi/lo value current at acceptance.
REQ-021 FSM states IDLE, MUL, DIV, DONE:
- IDLE->MUL on mult/multu; IDLE->DIV on div/divu.
- MUL/DIV->DONE after exactly WIDTH single-bit iterations (shift-add multiply, restoring divide on magnitudes).
- DONE->IDLE after one cycle.
REQ-022 ready_out SHALL be 0 from the cycle after a mult/div acceptance until the FSM returns to IDLE.
REQ-023 Latency: hi/lo update and the result_valid pulse (result=new lo) SHALL occur in DONE, WIDTH+1 cycles after acceptance; ready_out returns to 1 in the following cycle.
REQ-024 mult/multu SHALL set {hi,lo} to the full 2*WIDTH-bit product, signed or unsigned as selected.
REQ-025 div/divu SHALL set lo=quotient and hi=remainder; signed quotients truncate toward zero and the remainder takes the sign of a.
REQ-026 If b=0 for div/divu, the unit SHALL still take full latency, with hi=a, lo=all ones, and div_zero=1 on the result_valid pulse.
REQ-027 Signed division of the most-negative value by -1 SHALL give lo=most-negative and hi=0, with no flag.
REQ-028 Operands SHALL be captured at acceptance; changes on a/b/funct during MUL/DIV SHALL have no effect.
REQ-029 ovf and div_zero SHALL be 0 whenever result_valid=0.

Reset
REQ-030 rst=1 SHALL immediately force:
- FSM to IDLE and iteration counter to 0
- result, hi, lo to 0
- result_valid, ovf, div_zero to 0
- ready_out to 1 (next accept possible on the first edge after rst falls).
REQ-031 Assertion of rst during MUL/DIV SHALL abort the operation; no result_valid pulse and no hi/lo update SHALL follow.

Verification
REQ-032 WIDTH=32: add with a=7FFFFFFF, b=1, funct 100000 -> next cycle result=80000000, ovf=1, result_valid=1; the same operands with addu -> ovf=0.
REQ-033 multu a=FFFFFFFF, b=FFFFFFFF -> 33 cycles after acceptance hi=FFFFFFFE, lo=00000001, result_valid pulses once, ready_out=0 throughout the operation.
REQ-034 div a=-7, b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1); then mflo -> result=FFFFFFFD one cycle later.
REQ-035 divu a=5, b=0 -> after 33 cycles hi=5, lo=FFFFFFFF, div_zero=1 for one cycle.
REQ-036 Start mult, assert rst at iteration 10 for 1 cycle -> hi=lo=0, ready_out=1, no result_valid pulse afterwards.
REQ-037 WIDTH=8: mult a=80, b=FF -> 9 cycles after acceptance {hi,lo}=0080 (signed -128*-1); also a request held with valid_in=1 while ready_out=0 is ignored.
